// File: rtl/xorshift_rng_ranged.sv
// ============================================================================
// Module   : xorshift_rng_ranged
// Brief    : Parametrised xorshift generator with a free-running output and an
//            unbiased mask-and-reject ranged draw port (req/valid/ready).
//            Optional macro XORSHIFT_DRAW_CNT_EN adds the draw_cnt output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xorshift_rng_ranged #(
    parameter int               WIDTH   = 16,
    parameter int               SHIFT_A = 7,
    parameter int               SHIFT_B = 9,
    parameter int               SHIFT_C = 8,
    parameter logic [WIDTH-1:0] SEED    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] xs,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] rnd,
    output logic             valid,
`ifdef XORSHIFT_DRAW_CNT_EN
    output logic [7:0]       draw_cnt,
`endif
    input  logic             ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cand;
`ifdef XORSHIFT_DRAW_CNT_EN
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       dcnt_q, dcnt_d;
`endif

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] t;
        t = x ^ (x << SHIFT_A);
        t = t ^ (t >> SHIFT_B);
        t = t ^ (t << SHIFT_C);
        return t;
    endfunction

    // Smallest 2^k-1 covering v: propagate the top set bit into all lower bits.
    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        rnd_d   = rnd_q;
        valid_d = valid_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        cand    = xs_q & mask_q;
`ifdef XORSHIFT_DRAW_CNT_EN
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
`endif

        if (seed_load) begin
            xs_d = (seed_in == '0) ? SEED : seed_in;
        end else if (state_q == S_DRAW || en) begin
            xs_d = step(xs_q);
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    lim_d   = limit;
                    mask_d  = (limit == '0) ? '1 : smear(limit - 1'b1);
                    state_d = S_DRAW;
`ifdef XORSHIFT_DRAW_CNT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            S_DRAW: begin
                if (lim_q == '0 || cand < lim_q) begin
                    rnd_d   = cand;
                    valid_d = 1'b1;
                    state_d = S_DONE;
`ifdef XORSHIFT_DRAW_CNT_EN
                    dcnt_d  = cnt_q;
`endif
                end else begin
`ifdef XORSHIFT_DRAW_CNT_EN
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            S_DONE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            xs_q    <= SEED;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            lim_q   <= '0;
            mask_q  <= '0;
`ifdef XORSHIFT_DRAW_CNT_EN
            cnt_q   <= 8'd0;
            dcnt_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
`ifdef XORSHIFT_DRAW_CNT_EN
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
`endif
        end
    end

    assign xs    = xs_q;
    assign rnd   = rnd_q;
    assign valid = valid_q;
`ifdef XORSHIFT_DRAW_CNT_EN
    assign draw_cnt = dcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xorshift_rng_ranged.sv
// ============================================================================
// Module   : tb_xorshift_rng_ranged
// Brief    : Self-checking bench for xorshift_rng_ranged (WIDTH=16 defaults).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xorshift_rng_ranged;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0;
    logic [15:0] xs;
    logic        req = 1'b0;
    logic [15:0] limit = 16'h0;
    logic [15:0] rnd;
    logic        valid;
    logic        ready = 1'b0;
`ifdef XORSHIFT_DRAW_CNT_EN
    logic [7:0]  draw_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] m_xs;
    logic [15:0] m_rnd;
    int          m_rej;

    xorshift_rng_ranged dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .xs        (xs),
        .req       (req),
        .limit     (limit),
        .rnd       (rnd),
        .valid     (valid),
`ifdef XORSHIFT_DRAW_CNT_EN
        .draw_cnt  (draw_cnt),
`endif
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Reference: the xorshift step as plain arithmetic on integers.
    function automatic logic [15:0] f(input logic [15:0] x);
        int unsigned v;
        v = x;
        v = (v ^ (v << 7)) & 32'hFFFF;
        v = (v ^ (v >> 9)) & 32'hFFFF;
        v = (v ^ (v << 8)) & 32'hFFFF;
        return v[15:0];
    endfunction

    function automatic int unsigned mask_of(input logic [15:0] lim);
        int unsigned m;
        if (lim == 16'h0) return 32'hFFFF;
        m = 0;
        while (m < int'(lim) - 1) m = m * 2 + 1;
        return m;
    endfunction

    // Walk the sequence x0, f(x0), ... until a candidate falls inside [0, lim).
    task automatic predict(input logic [15:0] x0, input logic [15:0] lim,
                           output logic [15:0] r, output int rej, output logic [15:0] xend);
        logic [15:0] x;
        int unsigned c;
        x = x0;
        rej = 0;
        r = 16'h0;
        for (int i = 0; i < 1000; i++) begin
            c = int'(x) & mask_of(lim);
            x = f(x);
            if (lim == 16'h0 || c < int'(lim)) begin
                r = c[15:0];
                break;
            end
            rej++;
        end
        xend = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_xs = 16'h0001;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed_in = s;
        tick();
        seed_load = 1'b0;
        m_xs = (s == 16'h0) ? 16'h0001 : s;
    endtask

    // Issue a draw with en=0 and check latency, value, resulting state.
    task automatic draw(input logic [15:0] lim, input string tag);
        logic [15:0] xend;
        int n;
        predict(m_xs, lim, m_rnd, m_rej, xend);
        en = 1'b0;
        req = 1'b1;
        limit = lim;
        tick();
        req = 1'b0;
        limit = 16'($urandom);
        n = 1;
        while (valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, m_rej + 2);
        check({tag, "_rnd"}, rnd, m_rnd);
        check({tag, "_xs"}, xs, xend);
`ifdef XORSHIFT_DRAW_CNT_EN
        check({tag, "_cnt"}, draw_cnt, (m_rej > 255) ? 255 : m_rej);
`endif
        m_xs = xend;
    endtask

    // Hold off the consumer, optionally free-running, then accept.
    task automatic accept(input int hold, input bit run, input string tag);
        for (int i = 0; i < hold; i++) begin
            req = 1'($urandom);
            en = run;
            tick();
            if (run) m_xs = f(m_xs);
            check({tag, "_hold_valid"}, valid, 1);
            check({tag, "_hold_rnd"}, rnd, m_rnd);
        end
        req = 1'b0;
        en = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({tag, "_released"}, valid, 0);
        check({tag, "_xs_after"}, xs, m_xs);
    endtask

    initial begin
        logic [15:0] xend, r, lim;
        int rej, mode;

        // Reset state
        do_reset();
        check("rst_xs", xs, 16'h0001);
        check("rst_valid", valid, 0);
        check("rst_rnd", rnd, 16'h0000);

        // Free-run
        en = 1'b1;
        tick();
        check("run1", xs, 16'h8181);
        tick();
        check("run2", xs, 16'h6021);
        check("run2_model", xs, f(f(16'h0001)));
        en = 1'b0;
        tick();
        tick();
        check("hold", xs, 16'h6021);

        // Seed loading
        load_seed(16'h0000);
        check("seed_zero", xs, 16'h0001);
        load_seed(16'hBEEF);
        check("seed_beef", xs, 16'hBEEF);
        en = 1'b1;
        load_seed(16'h1234);
        en = 1'b0;
        check("seed_wins", xs, 16'h1234);

        // Trivial bounds
        do_reset();
        draw(16'd1, "lim1");
        check("lim1_value", rnd, 16'h0000);
        accept(0, 1'b0, "lim1");
        do_reset();
        draw(16'd0, "lim0");
        check("lim0_value", rnd, 16'h0001);
        accept(0, 1'b0, "lim0");

        // Rejection path
        load_seed(16'h0007);
        draw(16'd7, "rej");
        check("rej_value", rnd, 16'h0006);
        check("rej_count", m_rej, 1);
        // Handshake with long hold and ignored req pulses
        accept(5, 1'b0, "hs");
        draw(16'd100, "hs_next");
        accept(3, 1'b1, "hs_run");

        // Seed load during DRAW: candidate uses the old xs (7, rejected)
        load_seed(16'h0007);
        req = 1'b1;
        limit = 16'd7;
        tick();
        req = 1'b0;
        seed_load = 1'b1;
        seed_in = 16'h0006;
        tick();
        seed_load = 1'b0;
        check("ld_draw_busy", valid, 0);
        check("ld_draw_xs", xs, 16'h0006);
        tick();
        check("ld_draw_valid", valid, 1);
        check("ld_draw_rnd", rnd, 16'h0006);
        check("ld_draw_xs2", xs, f(16'h0006));
`ifdef XORSHIFT_DRAW_CNT_EN
        check("ld_draw_cnt", draw_cnt, 1);
`endif
        m_xs = f(16'h0006);
        m_rnd = 16'h0006;
        accept(0, 1'b0, "ld_draw");

        // Reset while in DRAW
        load_seed(16'h0007);
        req = 1'b1;
        limit = 16'd7;
        tick();
        req = 1'b0;
        do_reset();
        check("rst_draw_valid", valid, 0);
        check("rst_draw_xs", xs, 16'h0001);
        tick();
        check("rst_draw_idle", valid, 0);
        draw(16'd1, "post_rst_draw");
        check("post_rst_draw_value", rnd, 16'h0000);

        // Reset while in DONE
        do_reset();
        check("rst_done_valid", valid, 0);
        check("rst_done_xs", xs, 16'h0001);
        check("rst_done_rnd", rnd, 16'h0000);
        draw(16'd0, "post_rst_done");
        check("post_rst_done_value", rnd, 16'h0001);
        accept(0, 1'b0, "post_rst_done");

        // Randomized draws against the sequence model
        for (int it = 0; it < 40; it++) begin
            load_seed(16'($urandom_range(1, 65535)));
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b1;
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                    tick();
                    m_xs = f(m_xs);
                end
                en = 1'b0;
            end
            mode = $urandom_range(0, 3);
            case (mode)
                0: lim = 16'h0;
                1: lim = 16'($urandom_range(1, 20));
                2: lim = 16'($urandom);
                default: lim = 16'((1 << $urandom_range(1, 14)) + 1);
            endcase
            predict(m_xs, lim, r, rej, xend);
            draw(lim, $sformatf("rand%0d", it));
            if (lim != 16'h0) check($sformatf("rand%0d_range", it), rnd < lim, 1);
            accept($urandom_range(0, 3), 1'($urandom), $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
